axis_cdc_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the primary-side (clk_p) input of the `axi_cdc` width-converting async FIFO among `N_REQ` AXI-Stream requesters. Grants are held for a whole packet, from first beat to the beat carrying `last`. Each requester supplies its own 2-bit split mode. The arbiter latches that mode at grant time and drives it, stable, onto the converter's `cfg` input for the whole packet. It sits entirely in the clk_p domain, directly upstream of `axi_cdc`.

---
 rtl/axis_cdc_arbiter.sv | 116 +++++++++++
 tb/tb_axis_cdc_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axis_cdc_arbiter.sv
// Packet-level round-robin arbiter feeding the primary side of the axi_cdc converter.
// Ownership is held from first beat to the last beat; cfg is latched at grant time.
module axis_cdc_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH_P = 64
) (
  input  logic                       clk_p,
  input  logic                       rst_p,
  input  logic [N_REQ*WIDTH_P-1:0]   req_data,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [2*N_REQ-1:0]         req_cfg,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH_P-1:0]         p_axis_data,
  output logic                       p_axis_valid,
  output logic                       p_axis_last,
  input  logic                       p_axis_ready,
  output logic [1:0]                 cfg,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy
);

  localparam int unsigned NR = N_REQ;
  localparam int unsigned WP = WIDTH_P;
  localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [1:0]       cfg_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [IW-1:0]    own, own_nxt;

  logic             found;
  logic [IW-1:0]    win;
  int unsigned      idx;
  int unsigned      own_base;
  logic             accept;

  // Owner index is kept alongside the one-hot grant so the datapath mux
  // needs no one-hot decode.
  always_ff @(posedge clk_p or negedge rst_p) begin
    if (!rst_p) begin
      state <= ARB;
      grant <= '0;
      cfg   <= '0;
      ptr   <= '0;
      own   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cfg   <= cfg_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(ptr) + k) % NR;
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    p_axis_valid = 1'b0;
    p_axis_data  = '0;
    p_axis_last  = 1'b0;
    req_ready    = '0;
    own_base     = 32'(own) * WP;
    if (state == LOCK) begin
      p_axis_valid   = req_valid[own];
      p_axis_data    = req_data[own_base +: WIDTH_P];
      p_axis_last    = req_last[own];
      req_ready[own] = p_axis_ready;
    end
  end

  assign accept = p_axis_valid && p_axis_ready;
  assign busy   = (state == LOCK);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cfg_nxt   = cfg;
    ptr_nxt   = ptr;
    own_nxt   = own;
    unique case (state)
      ARB: begin
        if (found) begin
          state_nxt      = LOCK;
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          own_nxt        = win;
          cfg_nxt        = req_cfg[32'(win)*2 +: 2];
        end
      end
      LOCK: begin
        if (accept && p_axis_last) begin
          state_nxt = ARB;
          grant_nxt = '0;
          ptr_nxt   = (32'(own) == NR - 1) ? '0 : own + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

endmodule

// File: tb/tb_axis_cdc_arbiter.sv
// Directed bench for axis_cdc_arbiter: reset, round-robin order, cfg latch,
// backpressure, owner valid gap and mid-packet asynchronous reset.
module tb_axis_cdc_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk_p = 1'b0;
  logic           rst_p;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [2*N-1:0] req_cfg;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   p_axis_data;
  logic           p_axis_valid;
  logic           p_axis_last;
  logic           p_axis_ready;
  logic [1:0]     cfg;
  logic [N-1:0]   grant;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  axis_cdc_arbiter #(.N_REQ(N), .WIDTH_P(W)) dut (
    .clk_p        (clk_p),
    .rst_p        (rst_p),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_cfg      (req_cfg),
    .req_ready    (req_ready),
    .p_axis_data  (p_axis_data),
    .p_axis_valid (p_axis_valid),
    .p_axis_last  (p_axis_last),
    .p_axis_ready (p_axis_ready),
    .cfg          (cfg),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk_p = ~clk_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_p);
    #1;
  endtask

  logic [3:0]  exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [63:0] bp_data [3] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                               64'h3333_3333_3333_3333};
  logic [4:0]  bp_pat = 5'b10101;

  initial begin
    int b;
    rst_p        = 1'b0;
    req_valid    = 4'hF;
    req_last     = '0;
    req_cfg      = '0;
    p_axis_ready = 1'b1;
    req_data     = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    // Reset held with all requesters valid
    cyc(); cyc();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg", cfg, 0);
    check("rst_pvalid", p_axis_valid, 0);
    check("rst_ready", req_ready, 0);
    rst_p = 1'b1;
    cyc();
    check("first_grant", grant, 4'b0001);
    check("first_busy", busy, 1);

    // Round-robin: 2-beat packets, 3 cycles per packet
    for (int p = 0; p < 5; p++) begin
      cyc();
      check("rr_hold", grant, (p == 0) ? 4'b0001 : exp_g[p-1]);
      req_last = 4'hF;
      #1 check("rr_last", p_axis_last, 1);
      cyc();
      check("rr_bubble", grant, 0);
      check("rr_bubble_busy", busy, 0);
      if (p == 4) begin
        req_valid = '0;
      end
      req_last = '0;
      if (p < 4) begin
        cyc();
        check("rr_grant", grant, exp_g[p]);
      end
    end

    // Cfg latch: requester 2, cfg 11, 3-beat packet (ptr now 1)
    req_valid = 4'b0100;
    req_cfg   = 8'b00_11_00_00;
    cyc();
    check("cfg_grant", grant, 4'b0100);
    check("cfg_latched", cfg, 2'b11);
    cyc();
    req_cfg = '0;
    #1 check("cfg_hold1", cfg, 2'b11);
    cyc();
    check("cfg_hold2", cfg, 2'b11);
    req_last = 4'b0100;
    #1 check("cfg_last", p_axis_last, 1);
    check("cfg_hold3", cfg, 2'b11);
    cyc();
    check("cfg_done", busy, 0);
    req_valid = '0;
    req_last  = '0;

    // Backpressure: owner 0, ready 1,0,1,0,1, 3 beats (ptr now 3)
    req_valid = 4'b0001;
    req_data[63:0] = bp_data[0];
    cyc();
    check("bp_grant", grant, 4'b0001);
    b = 0;
    for (int c = 0; c < 5; c++) begin
      p_axis_ready   = bp_pat[c];
      req_data[63:0] = bp_data[b];
      req_last       = (b == 2) ? 4'b0001 : 4'b0000;
      #1;
      check("bp_ready", req_ready, {3'b000, bp_pat[c]});
      check("bp_data", p_axis_data, bp_data[b]);
      check("bp_valid", p_axis_valid, 1);
      cyc();
      if (bp_pat[c]) b++;
    end
    check("bp_done_grant", grant, 0);
    check("bp_done_busy", busy, 0);
    req_valid    = '0;
    req_last     = '0;
    p_axis_ready = 1'b1;

    // Valid gap: owner 1 drops valid 5 cycles while requester 3 waits (ptr now 1)
    req_valid = 4'b1010;
    req_cfg   = 8'b10_00_00_00;
    cyc();
    check("gap_grant", grant, 4'b0010);
    cyc();
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("gap_pvalid", p_axis_valid, 0);
      check("gap_grant_hold", grant, 4'b0010);
      cyc();
    end
    req_valid = 4'b1010;
    req_last  = 4'b0010;
    #1 check("gap_resume", p_axis_valid, 1);
    cyc();
    check("gap_bubble", grant, 0);
    req_last  = '0;
    req_valid = 4'b1000;
    cyc();
    check("gap_next", grant, 4'b1000);
    check("gap_next_cfg", cfg, 2'b10);

    // Mid-packet asynchronous reset during beat 2
    cyc();
    #2;
    rst_p = 1'b0;
    #1;
    check("mrst_grant", grant, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cfg", cfg, 0);
    check("mrst_pvalid", p_axis_valid, 0);
    check("mrst_plast", p_axis_last, 0);
    check("mrst_pdata", p_axis_data, 0);
    check("mrst_ready", req_ready, 0);
    check("mrst_ptr", dut.ptr, 0);
    req_valid = 4'b1010;
    cyc();
    rst_p = 1'b1;
    cyc();
    check("mrst_regrant", grant, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
